// File: rtl/vm_pkg.sv
// Shared types and helpers for the multi-product vending core.
package vm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DELIVER = 2'd2,
      ST_REFUND  = 2'd3
   } vm_state_e;

   localparam int VM_MAX_PROD = 8;

   // Product 0 is the least significant slice.
   localparam logic [39:0] VM_DEF_PRICES = {10'd250, 10'd200, 10'd150, 10'd100};

   function automatic logic is_onehot(input logic [VM_MAX_PROD-1:0] v);
      return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
   endfunction

endpackage

// File: rtl/credit_to_bcd.sv
// Combinational double-dabble: binary credit to four packed BCD digits.
module credit_to_bcd #(
   parameter int CREDIT_W = 10
) (
   input  logic [CREDIT_W-1:0] bin_i,
   output logic [15:0]         bcd_o
);

   logic [15:0] bcd_s;

   // Add-3 correction on every digit before each shift of the next binary bit.
   always_comb begin
      bcd_s = 16'd0;
      for (int b = CREDIT_W - 1; b >= 0; b--) begin
         for (int d = 0; d < 4; d++) begin
            bcd_s[d*4 +: 4] = (bcd_s[d*4 +: 4] >= 4'd5) ? (bcd_s[d*4 +: 4] + 4'd3)
                                                          : bcd_s[d*4 +: 4];
         end
         bcd_s = {bcd_s[14:0], bin_i[b]};
      end
   end

   assign bcd_o = bcd_s;

endmodule

// File: rtl/vending_machine_multi.sv
// N-product vending core: coin credit, per-product price/stock, cancel,
// inactivity timeout and change return. All control outputs are registered.
module vending_machine_multi
   import vm_pkg::*;
#(
   parameter int                         N_PROD      = 4,
   parameter int                         CREDIT_W    = 10,
   parameter logic [N_PROD*CREDIT_W-1:0] PRICES      = VM_DEF_PRICES,
   parameter int                         MAX_CREDIT  = 995,
   parameter int                         STOCK_W     = 4,
   parameter int                         DELIVER_CYC = 8,
   parameter int                         TIMEOUT_CYC = 1000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                coin_valid,
   input  logic [CREDIT_W-1:0] coin_value,
   input  logic [N_PROD-1:0]   sel,
   input  logic                cancel,
   input  logic                refill,
   input  logic [2:0]          refill_idx,
   output logic [N_PROD-1:0]   product,
   output logic                delivered,
   output logic                change_valid,
   output logic [CREDIT_W-1:0] change_amount,
   output logic                coin_reject,
   output logic                err_funds,
   output logic                err_empty,
   output logic [CREDIT_W-1:0] credit,
   output logic [15:0]         disp_bcd
);

   localparam int IDX_W = (N_PROD > 1) ? $clog2(N_PROD) : 1;
   localparam int DC_W  = $clog2(DELIVER_CYC + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

   localparam logic [CREDIT_W:0]   MAX_C     = MAX_CREDIT[CREDIT_W:0];
   localparam logic [STOCK_W-1:0]  STOCK_MAX = {STOCK_W{1'b1}};
   localparam logic [DC_W-1:0]     DC_LAST   = DC_W'(DELIVER_CYC - 1);
   localparam logic [TO_W-1:0]     TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [N_PROD-1:0]   ONE_HOT0  = {{(N_PROD-1){1'b0}}, 1'b1};

   vm_state_e            state_q, state_d;
   logic [CREDIT_W-1:0]  credit_q, credit_d;
   logic [STOCK_W-1:0]   stock_q [N_PROD];
   logic [STOCK_W-1:0]   stock_d [N_PROD];
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DC_W-1:0]      dcnt_q, dcnt_d;
   logic [TO_W-1:0]      tcnt_q, tcnt_d;
   logic [N_PROD-1:0]    product_q, product_d;
   logic                 delivered_q, delivered_d;
   logic                 change_valid_q, change_valid_d;
   logic [CREDIT_W-1:0]  change_amount_q, change_amount_d;
   logic                 coin_reject_q, coin_reject_d;
   logic                 err_funds_q, err_funds_d;
   logic                 err_empty_q, err_empty_d;

   logic [CREDIT_W:0]    coin_sum_s;
   logic                 coin_ok_s;
   logic                 sel_ok_s;
   logic                 refill_ok_s;
   logic                 activity_s;
   logic [IDX_W-1:0]     sel_idx_s;
   logic [CREDIT_W-1:0]  sel_price_s;
   logic [STOCK_W-1:0]   sel_stock_s;

   // Input decode; the OR-gather is exact only when sel is one-hot, which gates its use.
   always_comb begin
      coin_sum_s  = {1'b0, credit_q} + {1'b0, coin_value};
      coin_ok_s   = (coin_sum_s <= MAX_C);
      sel_ok_s    = is_onehot(VM_MAX_PROD'(sel));
      refill_ok_s = refill && (int'(refill_idx) < N_PROD);
      activity_s  = (coin_valid && coin_ok_s) || (sel != '0);
      sel_idx_s   = '0;
      sel_price_s = '0;
      sel_stock_s = '0;
      for (int i = 0; i < N_PROD; i++) begin
         sel_idx_s   = sel_idx_s   | ({IDX_W{sel[i]}}    & IDX_W'(i));
         sel_price_s = sel_price_s | ({CREDIT_W{sel[i]}} & PRICES[i*CREDIT_W +: CREDIT_W]);
         sel_stock_s = sel_stock_s | ({STOCK_W{sel[i]}}  & stock_q[i]);
      end
   end

   // Next-state logic: cancel beats coin beats selection.
   always_comb begin
      state_d       = state_q;
      credit_d      = credit_q;
      stock_d       = stock_q;
      idx_d         = idx_q;
      dcnt_d        = '0;
      tcnt_d        = '0;
      coin_reject_d = 1'b0;
      err_funds_d   = 1'b0;
      err_empty_d   = 1'b0;
      case (state_q)
         ST_IDLE, ST_COLLECT: begin
            if ((state_q == ST_IDLE) && refill_ok_s) begin
               stock_d[refill_idx[IDX_W-1:0]] = STOCK_MAX;
            end else begin
               stock_d = stock_q;
            end
            if ((state_q == ST_COLLECT) && cancel) begin
               state_d = ST_REFUND;
            end else if (coin_valid) begin
               if (coin_ok_s) begin
                  credit_d = coin_sum_s[CREDIT_W-1:0];
                  state_d  = ST_COLLECT;
               end else begin
                  coin_reject_d = 1'b1;
               end
            end else if (sel_ok_s) begin
               if (sel_stock_s == '0) begin
                  err_empty_d = 1'b1;
               end else if (credit_q < sel_price_s) begin
                  err_funds_d = 1'b1;
               end else begin
                  credit_d           = credit_q - sel_price_s;
                  stock_d[sel_idx_s] = sel_stock_s - STOCK_W'(1);
                  idx_d              = sel_idx_s;
                  state_d            = ST_DELIVER;
               end
            end else begin
               state_d = state_q;
            end
            // Idle credit is refunded once the counter has seen TIMEOUT_CYC quiet cycles.
            if ((state_q == ST_COLLECT) && (state_d == ST_COLLECT) && !activity_s) begin
               if (tcnt_q == TO_LAST) begin
                  state_d = ST_REFUND;
               end else begin
                  tcnt_d = tcnt_q + TO_W'(1);
               end
            end else begin
               tcnt_d = '0;
            end
         end
         ST_DELIVER: begin
            coin_reject_d = coin_valid;
            if (dcnt_q == DC_LAST) begin
               state_d = (credit_q != '0) ? ST_REFUND : ST_IDLE;
            end else begin
               dcnt_d = dcnt_q + DC_W'(1);
            end
         end
         ST_REFUND: begin
            coin_reject_d = coin_valid;
            credit_d      = '0;
            state_d       = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output pulses are decoded from next state so they line up with the state they describe.
   always_comb begin
      product_d       = (state_d == ST_DELIVER) ? (ONE_HOT0 << idx_d) : '0;
      delivered_d     = (state_d == ST_DELIVER) && (dcnt_d == DC_LAST);
      change_valid_d  = (state_d == ST_REFUND);
      change_amount_d = change_valid_d ? credit_d : '0;
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q         <= ST_IDLE;
         credit_q        <= '0;
         for (int i = 0; i < N_PROD; i++) begin
            stock_q[i] <= STOCK_MAX;
         end
         idx_q           <= '0;
         dcnt_q          <= '0;
         tcnt_q          <= '0;
         product_q       <= '0;
         delivered_q     <= 1'b0;
         change_valid_q  <= 1'b0;
         change_amount_q <= '0;
         coin_reject_q   <= 1'b0;
         err_funds_q     <= 1'b0;
         err_empty_q     <= 1'b0;
      end else begin
         state_q         <= state_d;
         credit_q        <= credit_d;
         stock_q         <= stock_d;
         idx_q           <= idx_d;
         dcnt_q          <= dcnt_d;
         tcnt_q          <= tcnt_d;
         product_q       <= product_d;
         delivered_q     <= delivered_d;
         change_valid_q  <= change_valid_d;
         change_amount_q <= change_amount_d;
         coin_reject_q   <= coin_reject_d;
         err_funds_q     <= err_funds_d;
         err_empty_q     <= err_empty_d;
      end
   end

   credit_to_bcd #(
      .CREDIT_W (CREDIT_W)
   ) u_bcd (
      .bin_i (credit_q),
      .bcd_o (disp_bcd)
   );

   assign product       = product_q;
   assign delivered     = delivered_q;
   assign change_valid  = change_valid_q;
   assign change_amount = change_amount_q;
   assign coin_reject   = coin_reject_q;
   assign err_funds     = err_funds_q;
   assign err_empty     = err_empty_q;
   assign credit        = credit_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Scoreboard bench: stimulus queues expected pulses, a negedge monitor pops and compares.
module tb_vending_machine_multi;

   localparam int N  = 4;
   localparam int CW = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic          coin_valid;
   logic [CW-1:0] coin_value;
   logic [N-1:0]  sel;
   logic          cancel;
   logic          refill;
   logic [2:0]    refill_idx;
   logic [N-1:0]  product;
   logic          delivered;
   logic          change_valid;
   logic [CW-1:0] change_amount;
   logic          coin_reject;
   logic          err_funds;
   logic          err_empty;
   logic [CW-1:0] credit;
   logic [15:0]   disp_bcd;

   vending_machine_multi dut (
      .clk           (clk),
      .reset         (reset),
      .coin_valid    (coin_valid),
      .coin_value    (coin_value),
      .sel           (sel),
      .cancel        (cancel),
      .refill        (refill),
      .refill_idx    (refill_idx),
      .product       (product),
      .delivered     (delivered),
      .change_valid  (change_valid),
      .change_amount (change_amount),
      .coin_reject   (coin_reject),
      .err_funds     (err_funds),
      .err_empty     (err_empty),
      .credit        (credit),
      .disp_bcd      (disp_bcd)
   );

   always #5 clk = ~clk;

   localparam int K_DELIV = 0, K_CHANGE = 1, K_REJECT = 2, K_FUNDS = 3, K_EMPTY = 4;

   typedef struct {
      int kind;
      int data;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic expect_ev(input int k, input int d);
      ev_t e;
      e.kind = k;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic pop_cmp(input string name, input int k, input int d);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s unexpected pulse actual_data=%0d required=no pulse (t=%0t)", name, d, $time);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.data != d) begin
            errors++;
            $display("FAIL %s actual kind=%0d data=%0d required kind=%0d data=%0d (t=%0t)",
                     name, k, d, e.kind, e.data, $time);
         end
      end
   endtask

   // Delivered data = product*256 + number of consecutive cycles that product was held.
   initial begin
      int          run;
      logic [N-1:0] prev;
      run  = 0;
      prev = '0;
      forever begin
         @(negedge clk);
         if (product != '0 && product == prev) run++;
         else run = (product != '0) ? 1 : 0;
         prev = product;
         if (delivered)    pop_cmp("delivered",   K_DELIV,  int'(product) * 256 + run);
         if (change_valid) pop_cmp("change",      K_CHANGE, int'(change_amount));
         if (coin_reject)  pop_cmp("coin_reject", K_REJECT, int'(credit));
         if (err_funds)    pop_cmp("err_funds",   K_FUNDS,  int'(credit));
         if (err_empty)    pop_cmp("err_empty",   K_EMPTY,  int'(credit));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_n(input int n);
      repeat (n) tick();
   endtask

   task automatic coin(input int v);
      coin_valid = 1'b1;
      coin_value = CW'(v);
      tick();
      coin_valid = 1'b0;
      coin_value = '0;
   endtask

   task automatic sel_p(input logic [N-1:0] v);
      sel = v;
      tick();
      sel = '0;
   endtask

   task automatic cancel_p();
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
   endtask

   task automatic refill_p(input int idx);
      refill     = 1'b1;
      refill_idx = 3'(idx);
      tick();
      refill     = 1'b0;
      refill_idx = 3'd0;
   endtask

   initial begin
      int t0;
      int found;
      int stock2;
      reset = 1'b0; coin_valid = 1'b0; coin_value = '0; sel = '0;
      cancel = 1'b0; refill = 1'b0; refill_idx = 3'd0;
      stock2 = 15;
      wait_n(3);
      chk("rst_credit",  credit, 0);
      chk("rst_product", product, 0);
      chk("rst_bcd",     disp_bcd, 0);
      chk("rst_change",  change_amount, 0);
      reset = 1'b1;
      tick();

      // Exact-price vend of product 0: no change expected.
      coin(100);
      chk("credit_100", credit, 100);
      expect_ev(K_DELIV, 1 * 256 + 8);
      sel_p(4'b0001);
      chk("credit_after_vend0", credit, 0);
      chk("product0_on", product, 1);
      wait_n(10);
      chk("product_off", product, 0);

      // Selection in IDLE with zero credit.
      expect_ev(K_FUNDS, 0);
      sel_p(4'b0001);
      wait_n(2);

      // 200+50, product 2 (price 200), change 50.
      coin(200);
      coin(50);
      chk("bcd_250", disp_bcd, 16'h0250);
      expect_ev(K_DELIV, 4 * 256 + 8);
      expect_ev(K_CHANGE, 50);
      sel_p(4'b0100);
      stock2--;
      wait_n(12);
      chk("credit_after_change", credit, 0);
      chk("change_amount_idle", change_amount, 0);

      // Insufficient funds, multi-bit sel ignored, then cancel refunds.
      coin(100);
      expect_ev(K_FUNDS, 100);
      sel_p(4'b1000);
      sel_p(4'b0011);
      chk("credit_kept_100", credit, 100);
      expect_ev(K_CHANGE, 100);
      cancel_p();
      wait_n(3);
      chk("credit_after_cancel", credit, 0);

      // Credit ceiling and coin-with-sel collision.
      coin(500);
      coin(450);
      chk("credit_950", credit, 950);
      chk("bcd_950", disp_bcd, 16'h0950);
      expect_ev(K_REJECT, 950);
      coin(100);
      chk("credit_kept_950", credit, 950);
      expect_ev(K_REJECT, 950);
      coin_valid = 1'b1; coin_value = CW'(100); sel = 4'b0001;
      tick();
      coin_valid = 1'b0; coin_value = '0; sel = '0;
      wait_n(2);
      chk("credit_collide_950", credit, 950);
      chk("collide_no_product", product, 0);
      expect_ev(K_CHANGE, 950);
      cancel_p();
      wait_n(3);

      // Drain product 2, then sold-out and refill behaviour.
      while (stock2 > 0) begin
         coin(200);
         expect_ev(K_DELIV, 4 * 256 + 8);
         sel_p(4'b0100);
         stock2--;
         wait_n(10);
      end
      coin(200);
      refill_p(2);
      expect_ev(K_EMPTY, 200);
      sel_p(4'b0100);
      expect_ev(K_CHANGE, 200);
      cancel_p();
      wait_n(3);
      refill_p(2);
      coin(200);
      expect_ev(K_DELIV, 4 * 256 + 8);
      sel_p(4'b0100);
      chk("refill_vend_product", product, 4);
      wait_n(10);
      chk("refill_vend_credit", credit, 0);

      // Inactivity timeout.
      expect_ev(K_CHANGE, 50);
      coin(50);
      t0    = cyc;
      found = 0;
      for (int k = 0; k < 1100 && found == 0; k++) begin
         tick();
         if (change_valid) found = 1;
      end
      chk("timeout_latency", (found != 0) ? (cyc - t0) : -1, 1000);
      wait_n(2);
      chk("timeout_credit", credit, 0);

      // Reset during DELIVER drops product and credit, no pulses.
      coin(150);
      sel_p(4'b0001);
      wait_n(3);
      chk("pre_reset_product", product, 1);
      reset = 1'b0;
      tick();
      chk("mid_reset_product", product, 0);
      chk("mid_reset_credit", credit, 0);
      reset = 1'b1;
      wait_n(12);

      chk("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
